// File: rtl/ioctl_stream_master.sv
// ioctl_stream_master: initiator side of the core's ioctl download port.
// Streams a byte image from a request/valid byte source into the core: opens
// the ioctl_download window, waits SETUP_CYC cycles, then per byte fetches
// from the source, waits out ioctl_wait, strobes ioctl_wr once and idles
// GAP_CYC cycles. The window is held TAIL_CYC cycles after the last byte.
//
// Optional feature (macro IOCTL_STREAM_VERIFY_EN): after the window closes,
// every offset is refetched and compared against the core's ioctl_din
// readback; mismatches are counted in err_cnt (saturating). Without the
// macro err_cnt is tied to 0 and ioctl_din is ignored.
//
// Ports:
//   clk_48, reset_n             clock, asynchronous active-low reset
//   start, index, length        transfer request (sampled in IDLE only)
//   busy, done                  transfer status / end-of-transfer pulse
//   src_req, src_addr           byte fetch request to the source
//   src_valid, src_data         source response
//   ioctl_download/index/wr/addr/dout   ioctl initiator outputs
//   ioctl_wait                  core back-pressure
//   ioctl_din, err_cnt          readback and mismatch count (verify feature)
module ioctl_stream_master #(
    parameter int unsigned ADDR_W    = 25,
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned GAP_CYC   = 2,
    parameter int unsigned TAIL_CYC  = 4
) (
    input  logic              clk_48,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              src_req,
    output logic [ADDR_W-1:0] src_addr,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    input  logic              ioctl_wait,
    input  logic [7:0]        ioctl_din,
    output logic [15:0]       err_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ERR_W = 16;

`ifdef IOCTL_STREAM_VERIFY_EN
    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_FETCH, S_WAIT_SRC, S_WRITE, S_GAP, S_TAIL,
        S_VFETCH, S_VWAIT, S_VADDR, S_VCMP
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_FETCH, S_WAIT_SRC, S_WRITE, S_GAP, S_TAIL
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] off_q, off_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [7:0]        byte_q, byte_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              src_req_q, src_req_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              dl_q, dl_d;
    logic [7:0]        idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              last_c;

`ifdef IOCTL_STREAM_VERIFY_EN
    logic [ERR_W-1:0]  err_q, err_d;
`endif

    // Current offset is the final byte; off_q < len_q so the +1 cannot wrap.
    assign last_c = ((off_q + ADDR_W'(1)) == len_q);

    // State and output registers.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            off_q      <= '0;
            len_q      <= '0;
            byte_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            src_req_q  <= 1'b0;
            src_addr_q <= '0;
            dl_q       <= 1'b0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dout_q     <= '0;
`ifdef IOCTL_STREAM_VERIFY_EN
            err_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            off_q      <= off_d;
            len_q      <= len_d;
            byte_q     <= byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            src_req_q  <= src_req_d;
            src_addr_q <= src_addr_d;
            dl_q       <= dl_d;
            idx_q      <= idx_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
`ifdef IOCTL_STREAM_VERIFY_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        off_d      = off_q;
        len_d      = len_q;
        byte_d     = byte_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        src_req_d  = 1'b0;
        src_addr_d = src_addr_q;
        dl_d       = dl_q;
        idx_d      = idx_q;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        dout_d     = dout_q;
`ifdef IOCTL_STREAM_VERIFY_EN
        err_d      = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d   = index;
                    len_d   = length;
                    busy_d  = 1'b1;
                    dl_d    = 1'b1;
                    cnt_d   = '0;
                    off_d   = '0;
                    state_d = S_SETUP;
`ifdef IOCTL_STREAM_VERIFY_EN
                    err_d   = '0;
`endif
                end
            end

            S_SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (len_q == '0) ? S_TAIL : S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FETCH: begin
                src_req_d  = 1'b1;
                src_addr_d = off_q;
                state_d    = S_WAIT_SRC;
            end

            S_WAIT_SRC: begin
                if (src_valid) begin
                    byte_d  = src_data;
                    state_d = S_WRITE;
                end
            end

            // Strobe is registered, so wait rising during the strobe cycle
            // itself cannot cancel it.
            S_WRITE: begin
                if (!ioctl_wait) begin
                    wr_d   = 1'b1;
                    addr_d = off_q;
                    dout_d = byte_q;
                    cnt_d  = '0;
                    if (GAP_CYC == 0) begin
                        if (last_c) begin
                            state_d = S_TAIL;
                        end else begin
                            off_d   = off_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end

            // The strobe cycle is the first gap cycle.
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (last_c) begin
                        state_d = S_TAIL;
                    end else begin
                        off_d   = off_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_TAIL: begin
                if (cnt_q == CNT_W'(TAIL_CYC - 1)) begin
                    cnt_d = '0;
                    dl_d  = 1'b0;
`ifdef IOCTL_STREAM_VERIFY_EN
                    if (len_q != '0) begin
                        off_d   = '0;
                        state_d = S_VFETCH;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
`else
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef IOCTL_STREAM_VERIFY_EN
            S_VFETCH: begin
                src_req_d  = 1'b1;
                src_addr_d = off_q;
                state_d    = S_VWAIT;
            end

            // Present the readback address as soon as the reference byte lands.
            S_VWAIT: begin
                if (src_valid) begin
                    byte_d  = src_data;
                    addr_d  = off_q;
                    state_d = S_VADDR;
                end
            end

            // Address visible this cycle; the core answers in the next one.
            S_VADDR: begin
                state_d = S_VCMP;
            end

            S_VCMP: begin
                if ((ioctl_din != byte_q) && (err_q != {ERR_W{1'b1}})) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (last_c) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    off_d   = off_q + ADDR_W'(1);
                    state_d = S_VFETCH;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign src_req        = src_req_q;
    assign src_addr       = src_addr_q;
    assign ioctl_download = dl_q;
    assign ioctl_index    = idx_q;
    assign ioctl_wr       = wr_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_dout     = dout_q;

`ifdef IOCTL_STREAM_VERIFY_EN
    assign err_cnt = err_q;
`else
    logic unused_din;
    assign unused_din = ^ioctl_din;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_ioctl_stream_master.sv
// Directed bench for ioctl_stream_master: byte source model (latency 1),
// core model with registered readback, cycle-stamped event log.
module tb_ioctl_stream_master;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned SETUP  = 4;
    localparam int unsigned GAP    = 2;
    localparam int unsigned TAIL   = 4;

    logic              clk_48 = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        index = '0;
    logic [ADDR_W-1:0] length = '0;
    logic              busy, done, src_req;
    logic [ADDR_W-1:0] src_addr;
    logic              src_valid;
    logic [7:0]        src_data;
    logic              ioctl_download, ioctl_wr;
    logic [7:0]        ioctl_index, ioctl_dout;
    logic [ADDR_W-1:0] ioctl_addr;
    logic              ioctl_wait = 1'b0;
    logic [7:0]        ioctl_din;
    logic [15:0]       err_cnt;

    ioctl_stream_master #(
        .ADDR_W(ADDR_W), .SETUP_CYC(SETUP), .GAP_CYC(GAP), .TAIL_CYC(TAIL)
    ) dut (
        .clk_48(clk_48), .reset_n(reset_n), .start(start), .index(index),
        .length(length), .busy(busy), .done(done), .src_req(src_req),
        .src_addr(src_addr), .src_valid(src_valid), .src_data(src_data),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .ioctl_din(ioctl_din), .err_cnt(err_cnt)
    );

    always #5 clk_48 = ~clk_48;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Source model: one-cycle latency.
    logic [7:0] src_mem [16];
    always @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            src_valid <= 1'b0;
            src_data  <= '0;
        end else begin
            src_valid <= src_req;
            src_data  <= src_req ? src_mem[src_addr[3:0]] : 8'h00;
        end
    end

    // Core model: stores writes, registered readback with optional corruption.
    logic [7:0] core_mem [16];
    logic       corrupt = 1'b0;
    always @(posedge clk_48) begin
        if (ioctl_wr) core_mem[ioctl_addr[3:0]] <= ioctl_dout;
        ioctl_din <= core_mem[ioctl_addr[3:0]] ^
                     ((corrupt && ioctl_addr == ADDR_W'(2)) ? 8'h5A : 8'h00);
    end

    // Cycle counter and event log.
    int cyc = 0;
    always @(posedge clk_48) cyc <= cyc + 1;

    int   wr_addr [$];
    int   wr_data [$];
    int   wr_cyc  [$];
    int   wr_idx  [$];
    int   req_n = 0, done_n = 0, bad_wr = 0;
    int   done_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    logic dl_prev = 1'b0;

    always @(negedge clk_48) begin
        if (ioctl_wr) begin
            wr_addr.push_back(int'(ioctl_addr));
            wr_data.push_back(int'(ioctl_dout));
            wr_cyc.push_back(cyc);
            wr_idx.push_back(int'(ioctl_index));
        end
        if (ioctl_wr && !ioctl_download) bad_wr++;
        if (src_req) req_n++;
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (ioctl_download && !dl_prev) rise_cyc = cyc;
        if (!ioctl_download && dl_prev) fall_cyc = cyc;
        dl_prev = ioctl_download;
    end

    task automatic clear_log();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); wr_idx.delete();
        req_n = 0; done_n = 0; bad_wr = 0;
    endtask

    task automatic fill_src(input logic [7:0] base);
        for (int i = 0; i < 16; i++) src_mem[i] = base + 8'(i);
    endtask

    task automatic do_start(input logic [7:0] idx, input int len);
        @(negedge clk_48);
        start  = 1'b1;
        index  = idx;
        length = ADDR_W'(len);
        @(negedge clk_48);
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_48);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        repeat (2) @(negedge clk_48);
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < 200; i++) begin
            if (wr_addr.size() >= n) break;
            @(negedge clk_48);
        end
    endtask

    initial begin
        int rel;
        fill_src(8'hA0);
        for (int i = 0; i < 16; i++) core_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk_48);
        check("rst_ctrl", {27'd0, busy, done, src_req, ioctl_download, ioctl_wr}, 32'd0);
        check("rst_addr", 32'(ioctl_addr), 32'd0);
        check("rst_index", 32'(ioctl_index), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_48);

        // Basic four-byte transfer
        clear_log();
        do_start(8'h01, 4);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_dl", 32'(ioctl_download), 32'd1);
        wait_done("t1");
        check("t1_nstrobe", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("t1_data%0d", i), 32'(wr_data[i]), 32'(8'hA0 + i));
        end
        check("t1_index", 32'(wr_idx[0]), 32'h01);
        check("t1_setup_lat", 32'(wr_cyc[0] - rise_cyc), 32'(SETUP + 4));
        check("t1_period", 32'(wr_cyc[1] - wr_cyc[0]), 32'(4 + GAP));
        check("t1_period3", 32'(wr_cyc[3] - wr_cyc[2]), 32'(4 + GAP));
        check("t1_tail", 32'(fall_cyc - wr_cyc[3]), 32'(GAP + TAIL));
        check("t1_ndone", 32'(done_n), 32'd1);
        check("t1_nreq", 32'(req_n), 32'(`ifdef IOCTL_STREAM_VERIFY_EN 8 `else 4 `endif));
`ifndef IOCTL_STREAM_VERIFY_EN
        check("t1_done_at_fall", 32'(done_cyc), 32'(fall_cyc));
`endif
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_bad_wr", 32'(bad_wr), 32'd0);

        // Back-pressure on the second byte
        fill_src(8'h50);
        clear_log();
        do_start(8'h02, 3);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_48);
            if (ioctl_wr) break;
        end
        ioctl_wait = 1'b1;
        repeat (10) @(negedge clk_48);
        check("t2_hold_nstrobe", 32'(wr_addr.size()), 32'd1);
        rel = cyc;
        ioctl_wait = 1'b0;
        wait_done("t2");
        check("t2_nstrobe", 32'(wr_addr.size()), 32'd3);
        check("t2_release_cyc", 32'(wr_cyc[1]), 32'(rel + 1));
        check("t2_addr1", 32'(wr_addr[1]), 32'd1);
        check("t2_data1", 32'(wr_data[1]), 32'h51);
        check("t2_data2", 32'(wr_data[2]), 32'h52);

        // Empty transfer
        clear_log();
        do_start(8'h03, 0);
        wait_done("t3");
        check("t3_window", 32'(fall_cyc - rise_cyc), 32'(SETUP + TAIL));
        check("t3_nstrobe", 32'(wr_addr.size()), 32'd0);
        check("t3_nreq", 32'(req_n), 32'd0);
        check("t3_ndone", 32'(done_n), 32'd1);
        check("t3_done_at_fall", 32'(done_cyc), 32'(fall_cyc));

        // Start while busy is ignored
        fill_src(8'h10);
        clear_log();
        do_start(8'h22, 5);
        wait_strobes(2);
        do_start(8'h77, 1);
        wait_done("t4");
        check("t4_nstrobe", 32'(wr_addr.size()), 32'd5);
        check("t4_addr4", 32'(wr_addr[4]), 32'd4);
        check("t4_data4", 32'(wr_data[4]), 32'h14);
        check("t4_index", 32'(wr_idx[4]), 32'h22);
        check("t4_ndone", 32'(done_n), 32'd1);
        repeat (20) @(negedge clk_48);
        check("t4_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-transfer, then a clean restart
        fill_src(8'hC0);
        clear_log();
        do_start(8'h05, 6);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_48);
            if (ioctl_wr && wr_addr.size() >= 1 && ioctl_addr == ADDR_W'(1)) break;
        end
        reset_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {27'd0, busy, done, src_req, ioctl_download, ioctl_wr}, 32'd0);
        check("t5_rst_addr", 32'(ioctl_addr), 32'd0);
        check("t5_rst_dout", 32'(ioctl_dout), 32'd0);
        check("t5_rst_index", 32'(ioctl_index), 32'd0);
        repeat (2) @(negedge clk_48);
        reset_n = 1'b1;
        @(negedge clk_48);
        fill_src(8'h33);
        clear_log();
        do_start(8'h06, 2);
        wait_done("t5");
        check("t5_nstrobe", 32'(wr_addr.size()), 32'd2);
        check("t5_addr0", 32'(wr_addr[0]), 32'd0);
        check("t5_addr1", 32'(wr_addr[1]), 32'd1);
        check("t5_data1", 32'(wr_data[1]), 32'h34);
        check("t5_bad_wr", 32'(bad_wr), 32'd0);

`ifdef IOCTL_STREAM_VERIFY_EN
        // Readback verification: corrupted byte at address 2, then clean
        fill_src(8'h90);
        clear_log();
        corrupt = 1'b1;
        do_start(8'h07, 4);
        wait_done("t6");
        check("t6_err_corrupt", 32'(err_cnt), 32'd1);
        corrupt = 1'b0;
        clear_log();
        do_start(8'h07, 4);
        check("t6_err_cleared", 32'(err_cnt), 32'd0);
        wait_done("t6b");
        check("t6_err_clean", 32'(err_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ioctl_stream_master.md
Name: ioctl_stream_master

Overview:
- Initiator side of the core's ioctl download port; streams a byte image (ROM, BIOS, disk) from a byte source into the core.
- Drives ioctl_download, ioctl_index, ioctl_wr, ioctl_addr and ioctl_dout, and honours the core's ioctl_wait back-pressure.
- Sits in the simulation/HPS-side harness, directly facing the core's ioctl responder.

Parameters:
- ADDR_W, 25, width of ioctl_addr and of the length/address counters.
- SETUP_CYC, 4, cycles ioctl_download is high before the first write; valid range 1..255.
- GAP_CYC, 2, minimum idle cycles after each ioctl_wr pulse before the next; 0 allowed.
- TAIL_CYC, 4, cycles ioctl_download stays high after the last write; valid range 1..255.

Ports:
- clk_48  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- index  in  8  image index; latched on accepted start
- length  in  ADDR_W  byte count; latched on accepted start; 0 = empty transfer
- busy  out  1  high from accepted start until DONE
- done  out  1  one-cycle pulse at end of transfer
- src_req  out  1  one-cycle fetch request
- src_addr  out  ADDR_W  byte offset being fetched
- src_valid  in  1  source data valid, arrives 1..N cycles after src_req
- src_data  in  8  source byte, qualified by src_valid
- ioctl_download  out  1  transfer window
- ioctl_index  out  8  latched index
- ioctl_wr  out  1  one-cycle write strobe
- ioctl_addr  out  ADDR_W  byte address, valid with ioctl_wr
- ioctl_dout  out  8  byte, valid with ioctl_wr
- ioctl_wait  in  1  core back-pressure
- ioctl_din  in  8  core readback; used only with the optional feature
- err_cnt  out  16  mismatch count; used only with the optional feature

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0; state IDLE; counters 0. A reset mid-transfer drops ioctl_download immediately, with no tail.
- IDLE: on start, latch index and length, set busy and ioctl_download the next cycle, then go to SETUP.
- SETUP: count SETUP_CYC cycles.
  - length==0: go to TAIL.
  - Otherwise: go to FETCH.
- FETCH: pulse src_req for one cycle with src_addr = current offset, then go to WAIT_SRC.
- WAIT_SRC: wait for src_valid and capture src_data.
  - src_valid is ignored in every other state.
  - There is no timeout.
- WRITE:
  - ioctl_wait high: hold; no strobe.
  - ioctl_wait low: pulse ioctl_wr for exactly one cycle with ioctl_addr = offset and ioctl_dout = captured byte.
  - ioctl_addr/ioctl_dout stay stable until the next write.
  - ioctl_wait rising in the same cycle as the strobe does not cancel that strobe.
- GAP: count GAP_CYC cycles, then check whether more bytes remain.
  - Offset+1 == length: go to TAIL.
  - Otherwise: increment offset and go to FETCH.
  - GAP_CYC==0 skips counting.
- TAIL: hold ioctl_download for TAIL_CYC cycles, then drop it, pulse done, clear busy, and return to IDLE.
- ioctl_wr is never asserted while ioctl_download is low.
- The offset counter is ADDR_W wide. length = 2^ADDR_W-1 is the maximum; no wrap occurs.
- start while busy is ignored.
- ioctl_index is stable for the whole window.
- Minimum per-byte period is 3 + GAP_CYC + source latency cycles.

Optional Feature:
- Macro IOCTL_STREAM_VERIFY_EN.
- Defined:
  - After TAIL, a second pass runs with ioctl_download low.
  - Each offset is refetched from the source.
  - ioctl_addr is presented one cycle before sampling ioctl_din, and the sample is compared with the source byte.
  - err_cnt increments on each mismatch and saturates at 16'hFFFF.
  - err_cnt clears on accepted start.
  - done pulses after this second pass instead.
- Not defined:
  - err_cnt is tied to 0 and ioctl_din is unused.
  - The state machine has no verify states.

Test Plan:
- length=4, bytes A0..A3, index=8'h01, source latency 1, ioctl_wait=0 -> ioctl_download high 4 cycles before first ioctl_wr; exactly 4 single-cycle strobes at addr 0..3 with data A0..A3, spaced 2 idle cycles (GAP) plus fetch; download low 4 cycles after last; one done pulse.
- length=3, ioctl_wait held high for 10 cycles while the second byte is pending -> no strobe during wait; the second strobe occurs on the first cycle after wait falls; addr 1, data unchanged; 3 strobes total.
- length=0 -> download high for SETUP_CYC+TAIL_CYC cycles, zero strobes, zero src_req, one done pulse.
- start pulsed again mid-transfer with length=1 -> ignored; original length=5 completes with 5 strobes.
- reset_n asserted low after the 2nd strobe -> all outputs 0 in the same cycle (asynchronous); then a new start with length=2 -> clean transfer, addr restarts at 0.
- With IOCTL_STREAM_VERIFY_EN and a core model returning a corrupted byte at addr 2 of 4 -> err_cnt=1 at done; with matching readback err_cnt=0.
